// File: rtl/tl_periph_port_arbiter.sv
// Two-master, one-slave TileLink-UL arbiter placed in front of the TL-to-AHB
// peripheral-port bridge.
// - A channel: round-robin grant with a lock. Once a request has been offered
//   to the bridge, it stays offered until it is accepted.
// - D channel: responses are routed back using the master index carried in
//   source bit 4.
// - The number of accepted-but-unanswered requests is bounded.
// - A response that arrives with nothing outstanding is dropped and recorded
//   in a sticky error flag.
module tl_periph_port_arbiter #(
  parameter int MAX_INFLIGHT         = 2,
  parameter int M0_PRIORITY_ON_RESET = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  // master 0 A channel
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [2:0]  m0_a_size,
  input  logic [3:0]  m0_a_source,
  input  logic [29:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  // master 0 D channel
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [2:0]  m0_d_size,
  output logic [3:0]  m0_d_source,
  output logic        m0_d_denied,
  output logic        m0_d_corrupt,
  output logic [31:0] m0_d_data,
  // master 1 A channel
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [2:0]  m1_a_size,
  input  logic [3:0]  m1_a_source,
  input  logic [29:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  // master 1 D channel
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [2:0]  m1_d_size,
  output logic [3:0]  m1_d_source,
  output logic        m1_d_denied,
  output logic        m1_d_corrupt,
  output logic [31:0] m1_d_data,
  // slave A channel toward the bridge
  output logic        s_a_valid,
  input  logic        s_a_ready,
  output logic [2:0]  s_a_opcode,
  output logic [2:0]  s_a_param,
  output logic [2:0]  s_a_size,
  output logic [4:0]  s_a_source,
  output logic [29:0] s_a_address,
  output logic [3:0]  s_a_mask,
  output logic [31:0] s_a_data,
  // slave D channel from the bridge
  input  logic        s_d_valid,
  output logic        s_d_ready,
  input  logic [2:0]  s_d_opcode,
  input  logic [1:0]  s_d_param,
  input  logic [2:0]  s_d_size,
  input  logic [4:0]  s_d_source,
  input  logic        s_d_denied,
  input  logic        s_d_corrupt,
  input  logic [31:0] s_d_data,
  // status
  output logic [2:0]  inflight,
  output logic        err_d_unexpected
);

  localparam logic [2:0] MAX_CNT  = 3'(MAX_INFLIGHT);
  localparam logic       RR_RESET = (M0_PRIORITY_ON_RESET != 0) ? 1'b0 : 1'b1;

  logic [2:0] inflight_q, inflight_d;
  logic       err_q, err_d;
  logic       lock_q, lock_d;
  logic       lock_idx_q, lock_idx_d;
  logic       rr_q, rr_d;

  logic       grant_s;
  logic       can_issue_s;
  logic       gnt_valid_s;
  logic       a_fire_s;
  logic       d_any_s;
  logic       d_idx_s;
  logic       d_fire_s;

  // Pick the granted master: lock first, then the sole requester, then the rr pointer
  always_comb begin
    grant_s = rr_q;
    if (lock_q) begin
      grant_s = lock_idx_q;
    end else if (m0_a_valid && !m1_a_valid) begin
      grant_s = 1'b0;
    end else if (m1_a_valid && !m0_a_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = rr_q;
    end
  end

  // A-channel handshake and field mux toward the bridge; everything is gated off during reset
  always_comb begin
    can_issue_s = (inflight_q < MAX_CNT);
    gnt_valid_s = grant_s ? m1_a_valid : m0_a_valid;
    s_a_valid   = reset_n & can_issue_s & gnt_valid_s;
    m0_a_ready  = reset_n & can_issue_s & s_a_ready & ~grant_s;
    m1_a_ready  = reset_n & can_issue_s & s_a_ready & grant_s;
    a_fire_s    = s_a_valid & s_a_ready;
    if (grant_s) begin
      s_a_opcode  = m1_a_opcode;
      s_a_param   = m1_a_param;
      s_a_size    = m1_a_size;
      s_a_source  = {1'b1, m1_a_source};
      s_a_address = m1_a_address;
      s_a_mask    = m1_a_mask;
      s_a_data    = m1_a_data;
    end else begin
      s_a_opcode  = m0_a_opcode;
      s_a_param   = m0_a_param;
      s_a_size    = m0_a_size;
      s_a_source  = {1'b0, m0_a_source};
      s_a_address = m0_a_address;
      s_a_mask    = m0_a_mask;
      s_a_data    = m0_a_data;
    end
  end

  // D-channel routing by source tag; with nothing outstanding the response is sunk
  always_comb begin
    d_any_s    = (inflight_q != 3'd0);
    d_idx_s    = s_d_source[4];
    m0_d_valid = reset_n & s_d_valid & d_any_s & ~d_idx_s;
    m1_d_valid = reset_n & s_d_valid & d_any_s & d_idx_s;
    if (d_any_s) begin
      s_d_ready = reset_n & (d_idx_s ? m1_d_ready : m0_d_ready);
    end else begin
      s_d_ready = reset_n;
    end
    d_fire_s     = s_d_valid & s_d_ready & d_any_s;
    m0_d_opcode  = s_d_opcode;
    m0_d_param   = s_d_param;
    m0_d_size    = s_d_size;
    m0_d_source  = s_d_source[3:0];
    m0_d_denied  = s_d_denied;
    m0_d_corrupt = s_d_corrupt;
    m0_d_data    = s_d_data;
    m1_d_opcode  = s_d_opcode;
    m1_d_param   = s_d_param;
    m1_d_size    = s_d_size;
    m1_d_source  = s_d_source[3:0];
    m1_d_denied  = s_d_denied;
    m1_d_corrupt = s_d_corrupt;
    m1_d_data    = s_d_data;
  end

  // Next-state for the counter, lock, pointer and sticky error flag
  always_comb begin
    inflight_d = inflight_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    err_d      = err_q;
    case ({a_fire_s, d_fire_s})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
    if (a_fire_s) begin
      lock_d = 1'b0;
      rr_d   = ~grant_s;
    end else if (s_a_valid) begin
      // offered but not taken: hold this master until the bridge accepts it
      lock_d     = 1'b1;
      lock_idx_d = grant_s;
    end else begin
      lock_d = lock_q;
    end
    if (s_d_valid && !d_any_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= 3'd0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= 1'b0;
      rr_q       <= RR_RESET;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  assign inflight         = inflight_q;
  assign err_d_unexpected = err_q;

endmodule

// File: doc/tl_periph_port_arbiter.md
Name: tl_periph_port_arbiter

Overview:
- Two-master, one-slave TileLink-UL arbiter placed in front of the TL-to-AHB peripheral-port bridge.
- Shares the single bridge A channel between the core data port (m0) and the debug/front port (m1).
- Tags each forwarded request's source with the master index and routes D responses back by that tag.
- Bounds the number of in-flight transactions and flags protocol errors.

Parameters:
- MAX_INFLIGHT, 2, maximum accepted-but-unanswered requests (1..7).
- M0_PRIORITY_ON_RESET, 1, when 1 the round-robin pointer resets to favour m0; when 0 it resets to favour m1.

Ports:
- clock in 1: single clock; all state on rising edge.
- reset_n in 1: asynchronous, active-low reset.
- mX_a_valid (X=0,1) in 1 / mX_a_ready out 1: master A-channel handshake.
- mX_a_opcode, mX_a_param, mX_a_size in 3 each: A-channel fields.
- mX_a_source in 4: master-local source ID.
- mX_a_address in 30: byte address.
- mX_a_mask in 4: byte mask.
- mX_a_data in 32: write data.
- mX_d_valid out 1 / mX_d_ready in 1: master D-channel handshake.
- mX_d_opcode out 3, mX_d_param out 2, mX_d_size out 3: D-channel fields.
- mX_d_source out 4: returned master-local source ID.
- mX_d_denied out 1, mX_d_corrupt out 1: response status.
- mX_d_data out 32: read data.
- s_a_valid out 1 / s_a_ready in 1: A channel toward the bridge.
- s_a_opcode/param/size out 3 each; s_a_address out 30; s_a_mask out 4; s_a_data out 32.
- s_a_source out 5: {grant index, mX_a_source}.
- s_d_valid in 1 / s_d_ready out 1: D channel from the bridge.
- s_d_opcode in 3, s_d_param in 2, s_d_size in 3, s_d_source in 5, s_d_denied in 1, s_d_corrupt in 1, s_d_data in 32: D-channel fields from the bridge.
- inflight out 3: current outstanding count.
- err_d_unexpected out 1: sticky flag, set on a D response with no outstanding request.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - inflight=0, err_d_unexpected=0, lock=0.
  - rr pointer=0 if M0_PRIORITY_ON_RESET else 1.
  - All valid/ready outputs are 0 while reset_n=0.
- Arbitration (combinational grant, registered state):
  - can_issue = inflight < MAX_INFLIGHT.
  - If lock=1, grant = locked index.
  - Otherwise, if only one master is valid, grant that master; if both are valid, grant the rr pointer's master.
  - s_a_valid = can_issue & mG_a_valid. All s_a_* fields are a pure mux of the granted master, with s_a_source = {G, mG_a_source}.
  - mG_a_ready = can_issue & s_a_ready. The non-granted master's a_ready=0.
- Lock (keeps s_a_valid/fields irrevocable):
  - When s_a_valid & !s_a_ready, register lock=1 and locked index=G.
  - Clear lock on the A fire.
  - While locked, the other master cannot win even if the pointer favours it.
- Pointer update: on every A fire, rr pointer = ~G. There is no update without a fire.
- D routing:
  - Routing index T = s_d_source[4].
  - mT_d_valid = s_d_valid & (inflight!=0). Fields pass through; mT_d_source = s_d_source[3:0]. The other master's d_valid=0.
  - s_d_ready = mT_d_ready & (inflight!=0).
- Unexpected D: if s_d_valid & inflight==0, set err_d_unexpected=1, and s_d_ready=1 so the response is dropped. The flag stays set until reset.
- Inflight counter:
  - +1 on A fire, -1 on D fire, unchanged when both occur in the same cycle.
  - Never exceeds MAX_INFLIGHT; a_ready is suppressed at the limit even if a D fire occurs in the same cycle, so there is no comb path from d_ready to a_ready.
- Latency: zero-cycle pass-through on both channels; the block adds no pipeline registers.
- Reset mid-transaction: all state clears immediately. A response arriving later for a pre-reset request counts as unexpected and sets err_d_unexpected.

Test Plan:
- m0 only, Get addr 0x0000_1000, source 3, s_a_ready=1 -> s_a_source=0x03 same cycle; inflight 0->1; D with source 0x03 -> m0_d_valid=1, m0_d_source=3, inflight->0.
- Both masters valid every cycle, s_a_ready=1, d immediate -> grants alternate m0,m1,m0,m1; s_a_source[4] sequence 0,1,0,1.
- m1 granted with s_a_ready=0 for 3 cycles, m0 raises valid in cycle 2 -> s_a fields stay m1's, lock=1, m1 fires in cycle 4, then m0 is granted.
- MAX_INFLIGHT=2, two fires without D -> inflight=2, both a_ready=0; D source 0x10 fires -> m1 receives it, inflight=1, a_ready re-enabled the next cycle.
- s_d_valid with inflight=0 -> s_d_ready=1, no master d_valid, err_d_unexpected=1 and stays 1 until reset_n pulses low.
- reset_n low for 1 cycle with inflight=2 and lock=1 -> inflight=0, lock=0, pointer=0; the following stale D sets err_d_unexpected.
